// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-128 constants, FSM state type and GF(2^8) helpers
// Purpose: common definitions for the iterative AES-128 inverse cipher.
// Contents: NR/BLK_W constants, aes_state_e FSM encoding, GF(2^8) arithmetic
//           over x^8+x^4+x^3+x+1, InvShiftRows and InvMixColumns on a 128-bit
//           block with byte 0 in bits [127:120] (column-major state layout).
package aes_pkg;

  localparam int NR    = 10;
  localparam int BLK_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2,
    ST_DONE  = 2'd3
  } aes_state_e;

  function automatic logic [7:0] gf_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = gf_xtime(p);
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254; the chain yields 0 for 0 with no special case.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
    x2   = gf_mul(a, a);
    x3   = gf_mul(x2, a);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    x252 = gf_mul(x240, x12);
    return gf_mul(x252, x2);
  endfunction

  // Byte (r,c) lives at index r+4c; row r is rotated right by r positions.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-8*(4*c)   -: 8];
      a1 = s[127-8*(4*c+1) -: 8];
      a2 = s[127-8*(4*c+2) -: 8];
      a3 = s[127-8*(4*c+3) -: 8];
      o[127-8*(4*c)   -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[127-8*(4*c+1) -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[127-8*(4*c+2) -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[127-8*(4*c+3) -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// rtl/aes_inv_sbox.sv - combinational AES inverse S-box
// Purpose: one-byte inverse S-box, inverse affine transform then GF(2^8) inverse.
// Ports: data_i - input byte; data_o - substituted byte.
module aes_inv_sbox
  import aes_pkg::*;
(
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);

  logic [7:0] aff_w;

  // Inverse affine: rotl1 ^ rotl3 ^ rotl6 ^ 0x05.
  assign aff_w  = {data_i[6:0], data_i[7]}
                ^ {data_i[4:0], data_i[7:5]}
                ^ {data_i[1:0], data_i[7:2]}
                ^ 8'h05;
  assign data_o = gf_inv(aff_w);

endmodule

// File: rtl/aes128_dec_iter.sv
// rtl/aes128_dec_iter.sv - iterative AES-128 inverse cipher, one round per clock
// Purpose: decrypts one 128-bit block in 11 cycles using externally stored round keys.
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_data ciphertext input;
//        key_idx/key_data same-cycle round-key lookup; out_valid/out_ready/out_data
//        plaintext output, held stable while stalled.
module aes128_dec_iter
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   key_idx,
  input  logic [127:0] key_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  aes_state_e   state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] data_q, data_d;

  logic [127:0] isr_w;
  logic [127:0] sub_w;
  logic [127:0] ark_w;
  logic [127:0] imc_w;

  assign isr_w = inv_shift_rows(data_q);

  for (genvar g = 0; g < 16; g++) begin : g_sbox
    aes_inv_sbox u_sbox (
      .data_i (isr_w[8*g +: 8]),
      .data_o (sub_w[8*g +: 8])
    );
  end

  assign ark_w = sub_w ^ key_data;
  assign imc_w = inv_mix_columns(ark_w);

  always_comb begin
    case (state_q)
      ST_IDLE:  key_idx = 4'(NR);
      ST_ROUND: key_idx = rnd_q;
      ST_FINAL: key_idx = 4'd0;
      default:  key_idx = 4'(NR);
    endcase
  end

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          data_d  = in_data ^ key_data;
          rnd_d   = 4'(NR - 1);
          state_d = ST_ROUND;
        end
      end
      ST_ROUND: begin
        data_d = imc_w;
        rnd_d  = rnd_q - 4'd1;
        if (rnd_q == 4'd1) state_d = ST_FINAL;
      end
      ST_FINAL: begin
        data_d  = ark_w;
        state_d = ST_DONE;
      end
      default: begin
        if (out_ready) state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rnd_q   <= 4'd0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      data_q  <= data_d;
    end
  end

  // rst_n gates in_ready so nothing is accepted while reset is asserted.
  assign in_ready  = rst_n && (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  // Intermediate round states never leave the block.
  assign out_data  = out_valid ? data_q : '0;

endmodule
